// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator on the icosoc control bus.
// A shared prescaler and period counter feed CHANNELS compare outputs.
// Edge-aligned or center-aligned counting, with per-channel polarity.
// Period, duty and mode changes are staged in shadow registers.
// They load into the active set only at a period boundary, so an output
// never glitches mid-period. A sticky WRAP flag marks each boundary and
// can raise a level interrupt so the CPU can refresh duties in time.
module pwm_multi #(
    parameter int CHANNELS       = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [3:0]          ctrl_wr,
    input  logic                ctrl_rd,
    input  logic [15:0]         ctrl_addr,
    input  logic [31:0]         ctrl_wdat,
    output logic [31:0]         ctrl_rdat,
    output logic                ctrl_done,
    output logic [CHANNELS-1:0] pins,
    output logic                irq
);

    localparam logic [15:0] ADDR_CTRL     = 16'h0000;
    localparam logic [15:0] ADDR_PRESCALE = 16'h0004;
    localparam logic [15:0] ADDR_PERIOD   = 16'h0008;
    localparam logic [15:0] ADDR_STATUS   = 16'h000C;
    localparam logic [15:0] ADDR_COUNTER  = 16'h0010;
    localparam logic [15:0] ADDR_POLARITY = 16'h0014;

    localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = 1;
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = 1;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                      r_enable;
    logic                      r_mode;       // shadow mode, as written by the CPU
    logic                      r_mode_act;   // mode the counter is actually using
    logic                      r_irq_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [CNT_WIDTH-1:0]      r_period_sh;
    logic [CNT_WIDTH-1:0]      r_period_act;
    logic [CNT_WIDTH-1:0]      r_duty_sh  [CHANNELS];
    logic [CNT_WIDTH-1:0]      r_duty_act [CHANNELS];
    logic [CHANNELS-1:0]       r_polarity;
    logic                      r_wrap;
    logic                      r_pending;

    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic [CNT_WIDTH-1:0]      r_counter;
    logic                      r_dir_down;
    logic [CHANNELS-1:0]       r_pins;

    logic                      r_done;
    logic [31:0]               r_rdat;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                      w_bus_wr;
    logic                      w_bus_req;
    logic                      w_ctrl_we;
    logic                      w_presc_we;
    logic                      w_period_we;
    logic                      w_status_we;
    logic                      w_pol_we;
    logic                      w_duty_hit;
    logic [2:0]                w_duty_idx;
    logic [CHANNELS-1:0]       w_duty_we;
    logic                      w_shadow_wr;
    logic [31:0]               w_rdat;
    logic                      w_unused;

    // A request is only taken while no acknowledge is in flight, which
    // keeps ctrl_done from ever asserting on two consecutive cycles.
    assign w_bus_wr    = (|ctrl_wr) && !r_done;
    assign w_bus_req   = (w_bus_wr || ctrl_rd) && !r_done;

    assign w_ctrl_we   = w_bus_wr && (ctrl_addr == ADDR_CTRL);
    assign w_presc_we  = w_bus_wr && (ctrl_addr == ADDR_PRESCALE);
    assign w_period_we = w_bus_wr && (ctrl_addr == ADDR_PERIOD);
    assign w_status_we = w_bus_wr && (ctrl_addr == ADDR_STATUS);
    assign w_pol_we    = w_bus_wr && (ctrl_addr == ADDR_POLARITY);

    // Duty registers live at 0x20..0x3C, word aligned.
    assign w_duty_hit  = (ctrl_addr[15:5] == 11'd1) && (ctrl_addr[1:0] == 2'b00);
    assign w_duty_idx  = ctrl_addr[4:2];

    // Only the low bits of the write data are used by any register.
    assign w_unused    = ^ctrl_wdat;

    // ------------------------------------------------------------------
    // Shadow next-values: what each shadow holds after this cycle. The
    // active set loads from these so that a write landing on a boundary
    // goes straight into the period that is starting.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]      w_period_sh_next;
    logic [CNT_WIDTH-1:0]      w_duty_sh_next [CHANNELS];
    logic                      w_mode_next;
    logic [CHANNELS-1:0]       w_raw;

    assign w_period_sh_next = w_period_we ? ctrl_wdat[CNT_WIDTH-1:0] : r_period_sh;
    assign w_mode_next      = w_ctrl_we ? ctrl_wdat[1] : r_mode;
    assign w_shadow_wr      = w_period_we || (|w_duty_we);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_duty_we[gi]      = w_bus_wr && w_duty_hit && (w_duty_idx == 3'(gi));
        assign w_duty_sh_next[gi] = w_duty_we[gi] ? ctrl_wdat[CNT_WIDTH-1:0] : r_duty_sh[gi];
        // Compare against the active duty only; D=0 never fires, D>P always does.
        assign w_raw[gi]          = (r_counter < r_duty_act[gi]);
    end

    // ------------------------------------------------------------------
    // Prescaler and counter stepping
    // ------------------------------------------------------------------
    logic [PRESCALE_WIDTH-1:0] w_presc_next;
    logic [CNT_WIDTH-1:0]      w_cnt_next;
    logic                      w_dir_next;
    logic                      w_tick;
    logic                      w_boundary;

    // Compute the next prescaler/counter/direction and flag period boundaries.
    always_comb begin
        w_presc_next = r_presc_cnt;
        w_cnt_next   = r_counter;
        w_dir_next   = r_dir_down;
        w_tick       = 1'b0;
        w_boundary   = 1'b0;
        if (r_enable) begin
            // >= rather than == so a PRESCALE lowered below the running
            // count still produces a tick instead of wrapping the prescaler.
            if (r_presc_cnt >= r_prescale) begin
                w_tick       = 1'b1;
                w_presc_next = '0;
            end else begin
                w_presc_next = r_presc_cnt + PRESC_ONE;
            end

            if (w_tick) begin
                if (!r_mode_act) begin
                    // Edge aligned: 0..P then wrap, P+1 ticks per period.
                    if (r_counter >= r_period_act) begin
                        w_cnt_next = '0;
                        w_dir_next = 1'b0;
                        w_boundary = 1'b1;
                    end else begin
                        w_cnt_next = r_counter + CNT_ONE;
                    end
                end else if (r_dir_down) begin
                    // Center aligned, falling slope: arriving at 0 ends the period.
                    if (r_counter <= CNT_ONE) begin
                        w_cnt_next = '0;
                        w_dir_next = 1'b0;
                        w_boundary = 1'b1;
                    end else begin
                        w_cnt_next = r_counter - CNT_ONE;
                    end
                end else if (r_counter >= r_period_act) begin
                    // Center aligned, top of the ramp. For P<=1 the down
                    // slope is empty, so the next value is already 0.
                    if (r_period_act <= CNT_ONE) begin
                        w_cnt_next = '0;
                        w_dir_next = 1'b0;
                        w_boundary = 1'b1;
                    end else begin
                        w_cnt_next = r_period_act - CNT_ONE;
                        w_dir_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_counter + CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (shadow values, current counter)
    // ------------------------------------------------------------------

    // Select read data for the addressed register; unmapped reads give 0.
    always_comb begin
        w_rdat = '0;
        case (ctrl_addr)
            ADDR_CTRL:     w_rdat[2:0]                = {r_irq_en, r_mode, r_enable};
            ADDR_PRESCALE: w_rdat[PRESCALE_WIDTH-1:0] = r_prescale;
            ADDR_PERIOD:   w_rdat[CNT_WIDTH-1:0]      = r_period_sh;
            ADDR_STATUS:   w_rdat[1:0]                = {r_pending, r_wrap};
            ADDR_COUNTER:  w_rdat[CNT_WIDTH-1:0]      = r_counter;
            ADDR_POLARITY: w_rdat[CHANNELS-1:0]       = r_polarity;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_duty_hit && (w_duty_idx == 3'(i))) begin
                        w_rdat[CNT_WIDTH-1:0] = r_duty_sh[i];
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Bus acknowledge and registered read data (zero outside the ack cycle).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_done <= 1'b0;
            r_rdat <= '0;
        end else begin
            r_done <= w_bus_req;
            r_rdat <= w_bus_req ? w_rdat : 32'd0;
        end
    end

    // CPU-visible configuration registers and shadows.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_enable    <= 1'b0;
            r_mode      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_prescale  <= '0;
            r_period_sh <= '0;
            r_polarity  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= '0;
            end
        end else begin
            if (w_ctrl_we) begin
                r_enable <= ctrl_wdat[0];
                r_irq_en <= ctrl_wdat[2];
            end
            r_mode      <= w_mode_next;
            r_period_sh <= w_period_sh_next;
            if (w_presc_we) begin
                r_prescale <= ctrl_wdat[PRESCALE_WIDTH-1:0];
            end
            if (w_pol_we) begin
                r_polarity <= ctrl_wdat[CHANNELS-1:0];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= w_duty_sh_next[i];
            end
        end
    end

    // Timebase, active set, status flags and output pins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_presc_cnt  <= '0;
            r_counter    <= '0;
            r_dir_down   <= 1'b0;
            r_period_act <= '0;
            r_mode_act   <= 1'b0;
            r_pending    <= 1'b0;
            r_wrap       <= 1'b0;
            r_pins       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_act[i] <= '0;
            end
        end else begin
            // A boundary setting WRAP wins over a simultaneous clear.
            if (w_boundary) begin
                r_wrap <= 1'b1;
            end else if (w_status_we && ctrl_wdat[0]) begin
                r_wrap <= 1'b0;
            end

            if (r_enable) begin
                r_presc_cnt <= w_presc_next;
                r_counter   <= w_cnt_next;
                r_dir_down  <= w_dir_next;
                r_pins      <= w_raw ^ r_polarity;
                if (w_boundary) begin
                    r_period_act <= w_period_sh_next;
                    r_mode_act   <= w_mode_next;
                    r_pending    <= 1'b0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_duty_act[i] <= w_duty_sh_next[i];
                    end
                end else if (w_shadow_wr) begin
                    r_pending <= 1'b1;
                end
            end else begin
                // Idle: timebase parked at 0, active set tracks the shadows
                // so the first period after enable uses fresh values.
                r_presc_cnt  <= '0;
                r_counter    <= '0;
                r_dir_down   <= 1'b0;
                r_pins       <= r_polarity;
                r_period_act <= w_period_sh_next;
                r_mode_act   <= w_mode_next;
                r_pending    <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty_act[i] <= w_duty_sh_next[i];
                end
            end
        end
    end

    assign ctrl_done = r_done;
    assign ctrl_rdat = r_rdat;
    assign pins      = r_pins;
    assign irq       = r_wrap && r_irq_en;

endmodule
